// File: rtl/baud_pkg.sv
// Shared constants for the fractional baud generator: system clock, default
// oversampling and the divisor pairs for the common baud rates.
package baud_pkg;

  localparam int unsigned SYS_CLK        = 100_000_000;
  localparam int unsigned OVERSAMPLE_DEF = 16;
  localparam int unsigned FRAC_W_DEF     = 4;

  // Cycles per oversample tick in FRAC_W_DEF fixed point, rounded to nearest.
  function automatic int unsigned div_fixed(input int unsigned baud);
    int unsigned step_rate;
    step_rate = baud * OVERSAMPLE_DEF;
    return ((SYS_CLK << FRAC_W_DEF) + step_rate / 32'd2) / step_rate;
  endfunction

  localparam int unsigned DIV_9600    = div_fixed(32'd9600) >> FRAC_W_DEF;
  localparam int unsigned FRAC_9600   = div_fixed(32'd9600) % (32'd1 << FRAC_W_DEF);
  localparam int unsigned DIV_115200  = div_fixed(32'd115200) >> FRAC_W_DEF;
  localparam int unsigned FRAC_115200 = div_fixed(32'd115200) % (32'd1 << FRAC_W_DEF);

endpackage

// File: rtl/baud_frac_div.sv
// Fractional clock divider: shadow divisor registers, phase accumulator and
// cycle counter producing one os_tick per (div + carry) cycle period.
module baud_frac_div #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned FRAC_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic              resync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick_c,
  output logic              os_tick
);

  localparam int unsigned CNT_W = DIV_W + 1;

  logic [DIV_W-1:0]  div_q, div_d, pdiv_q, pdiv_d, div_nxt, div_eff;
  logic [FRAC_W-1:0] frac_q, frac_d, pfrac_q, pfrac_d, frac_nxt, acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, len_q, len_d, len_cur, cnt_inc;
  logic [FRAC_W:0]   sum;
  logic              pend_q, pend_d, tick_q, tick_d, start;

  always_comb begin
    div_d   = div_q;
    frac_d  = frac_q;
    pdiv_d  = pdiv_q;
    pfrac_d = pfrac_q;
    pend_d  = pend_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    tick_d  = 1'b0;
    os_tick_c = 1'b0;

    div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;
    sum     = {1'b0, acc_q} + {1'b0, frac_q};
    start   = (cnt_q == '0);
    len_cur = start ? (CNT_W'(div_eff) + CNT_W'(sum[FRAC_W])) : len_q;
    cnt_inc = cnt_q + CNT_W'(1);
    // A fresh load wins over a deferred one whenever a boundary commits.
    div_nxt  = load ? div_int  : (pend_q ? pdiv_q  : div_q);
    frac_nxt = load ? div_frac : (pend_q ? pfrac_q : frac_q);

    if (!en || resync) begin
      cnt_d  = '0;
      acc_d  = '0;
      pend_d = 1'b0;
      div_d  = div_nxt;
      frac_d = frac_nxt;
    end else begin
      if (start) begin
        acc_d = sum[FRAC_W-1:0];
        len_d = len_cur;
      end
      if (cnt_inc == len_cur) begin
        os_tick_c = 1'b1;
        tick_d    = 1'b1;
        cnt_d     = '0;
        pend_d    = 1'b0;
        div_d     = div_nxt;
        frac_d    = frac_nxt;
      end else begin
        cnt_d = cnt_inc;
        // Mid-period loads wait for the end of the running period.
        if (load) begin
          pend_d  = 1'b1;
          pdiv_d  = div_int;
          pfrac_d = div_frac;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q   <= '0;
      frac_q  <= '0;
      pdiv_q  <= '0;
      pfrac_q <= '0;
      pend_q  <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      frac_q  <= frac_d;
      pdiv_q  <= pdiv_d;
      pfrac_q <= pfrac_d;
      pend_q  <= pend_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      tick_q  <= tick_d;
    end
  end

  assign os_tick = tick_q;

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional baud generator: oversample tick from the divider, plus bit
// tick and bit-rate square wave derived from the oversample index.
module baud_gen_frac
  import baud_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FRAC_W     = FRAC_W_DEF,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              resync,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              bclk
);

  localparam int unsigned     IDX_W    = $clog2(OVERSAMPLE);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(OVERSAMPLE / 2);

  logic             os_tick_c;
  logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
  logic             bit_tick_q, bit_tick_d, bclk_q, bclk_d;

  baud_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .load      (load),
    .resync    (resync),
    .div_int   (div_int),
    .div_frac  (div_frac),
    .os_tick_c (os_tick_c),
    .os_tick   (os_tick)
  );

  // Oversample index; resync lands mid-bit so the next bit tick is half a bit away.
  always_comb begin
    idx_d      = idx_q;
    bclk_d     = bclk_q;
    bit_tick_d = 1'b0;
    idx_inc    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);

    if (!en) begin
      idx_d  = '0;
      bclk_d = 1'b1;
    end else if (resync) begin
      idx_d  = IDX_HALF;
      bclk_d = 1'b0;
    end else if (os_tick_c) begin
      idx_d      = idx_inc;
      bit_tick_d = (idx_q == IDX_LAST);
      if (idx_inc == IDX_HALF) begin
        bclk_d = 1'b0;
      end else if (idx_inc == '0) begin
        bclk_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q      <= '0;
      bit_tick_q <= 1'b0;
      bclk_q     <= 1'b1;
    end else begin
      idx_q      <= idx_d;
      bit_tick_q <= bit_tick_d;
      bclk_q     <= bclk_d;
    end
  end

  assign bit_tick = bit_tick_q;
  assign bclk     = bclk_q;

endmodule
